// File: rtl/s2_port_master.sv
// Fabric-side initiator for the s2 port of the dual-port on-chip memory.
// Accepts single-word writes and burst reads (1..MAX_LEN words) on a
// valid/ready command port. Read data comes back on a fixed-latency
// response stream that has no backpressure.
module s2_port_master #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int BE_W       = 4,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LEN    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [4:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [BE_W-1:0]   cmd_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] s2_address,
  output logic              s2_chipselect,
  output logic              s2_clken,
  output logic              s2_write,
  output logic [DATA_W-1:0] s2_writedata,
  output logic [BE_W-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0] s2_readdata
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_DRAIN} state_t;

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    rem, rem_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [BE_W-1:0]     be_nxt;
  logic                cs_nxt, we_nxt, wr_done_nxt;
  logic                accept;
  logic                issue, issue_last;
  logic                drain_done;
  logic [RD_LATENCY-1:0] vld_p, last_p;

  // Saturate the requested burst length into 1..MAX_LEN.
  function automatic logic [LEN_W-1:0] eff_len(input logic [4:0] len);
    if (len == 5'd0) return LEN_W'(1);
    if (int'(len) > MAX_LEN) return LEN_W'(MAX_LEN);
    return LEN_W'(len);
  endfunction

  // Ready is held low while reset is asserted, so it depends on reset directly.
  assign cmd_ready  = (state == IDLE) && !reset;
  assign accept     = cmd_valid && cmd_ready;
  assign issue      = (state == RD_ISSUE);
  assign issue_last = issue && (rem == LEN_W'(1));
  // The last token reaching the output stage means the pipe empties this edge.
  assign drain_done = vld_p[RD_LATENCY-1] && last_p[RD_LATENCY-1];

  // Next-state and next-output decode; every s2 output is registered from these.
  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem;
    addr_nxt    = s2_address;
    wdata_nxt   = s2_writedata;
    be_nxt      = s2_byteenable;
    cs_nxt      = 1'b0;
    we_nxt      = 1'b0;
    wr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          addr_nxt = cmd_addr;
          cs_nxt   = 1'b1;
          if (cmd_write) begin
            state_nxt   = WR;
            we_nxt      = 1'b1;
            wr_done_nxt = 1'b1;
            wdata_nxt   = cmd_wdata;
            be_nxt      = cmd_be;
          end else begin
            state_nxt = RD_ISSUE;
            be_nxt    = '1;
            rem_nxt   = eff_len(cmd_len);
          end
        end
      end
      WR: begin
        state_nxt = IDLE;
      end
      RD_ISSUE: begin
        if (rem == LEN_W'(1)) begin
          state_nxt = RD_DRAIN;
        end else begin
          cs_nxt   = 1'b1;
          addr_nxt = s2_address + ADDR_W'(1);
          rem_nxt  = rem - LEN_W'(1);
        end
      end
      RD_DRAIN: begin
        if (drain_done) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered s2 / status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rem           <= '0;
      s2_address    <= '0;
      s2_writedata  <= '0;
      s2_byteenable <= '0;
      s2_chipselect <= 1'b0;
      s2_write      <= 1'b0;
      s2_clken      <= 1'b0;
      wr_done       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      rem           <= rem_nxt;
      s2_address    <= addr_nxt;
      s2_writedata  <= wdata_nxt;
      s2_byteenable <= be_nxt;
      s2_chipselect <= cs_nxt;
      s2_write      <= we_nxt;
      s2_clken      <= 1'b1;
      wr_done       <= wr_done_nxt;
      busy          <= (state_nxt != IDLE);
    end
  end

  // Read token pipeline: one stage per cycle of s2 read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p[0]  <= issue;
      last_p[0] <= issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
      end
    end
  end

  // Response stage: capture s2_readdata when a token leaves the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= vld_p[RD_LATENCY-1];
      rsp_last  <= vld_p[RD_LATENCY-1] && last_p[RD_LATENCY-1];
      if (vld_p[RD_LATENCY-1]) rsp_data <= s2_readdata;
    end
  end

endmodule
